irq_req_capture: RTL and testbench

- Upstream stage of the 8-input priority encoder.
- Synchronises eight asynchronous request lines and edge-detects them. Latches each event as a pending bit until the consumer acknowledges it by index.
- Presents the masked pending vector and the encoder's active-high disable to the encoder.
- Also provides sticky per-line overflow flags and a pending count for status readback.

---
 rtl/irq_pkg.sv | 20 ++
 rtl/irq_sync_edge.sv | 53 +++++
 rtl/irq_req_capture.sv | 79 +++++++
 tb/tb_irq_req_capture.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared types and constants for the 8-line interrupt path. The encoder and
// downstream consumers import this package too.
package irq_pkg;

    localparam int N_IRQ     = 8;
    localparam int IRQ_IDX_W = 3;

    typedef logic [N_IRQ-1:0]     irq_vec_t;
    typedef logic [IRQ_IDX_W-1:0] irq_idx_t;

    function automatic logic [IRQ_IDX_W:0] irq_popcount(input irq_vec_t v);
        logic [IRQ_IDX_W:0] cnt;
        cnt = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            cnt = cnt + {{IRQ_IDX_W{1'b0}}, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Multi-stage synchroniser for the request vector followed by a rising-edge
// or level event detector.
module irq_sync_edge
    import irq_pkg::*;
#(
    parameter int N           = N_IRQ,
    parameter int SYNC_STAGES = 2,
    parameter int LEVEL_MODE  = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_in,
    output logic [N-1:0] evt
);

    logic [N-1:0] sync_q [SYNC_STAGES];
    logic [N-1:0] sync_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= req_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync_last = sync_q[SYNC_STAGES-1];

    generate
        if (LEVEL_MODE != 0) begin : g_level
            assign evt = sync_last;
        end else begin : g_edge
            // prev clears on reset, so a line held high through reset fires once
            logic [N-1:0] prev_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    prev_q <= '0;
                end else begin
                    prev_q <= sync_last;
                end
            end

            assign evt = sync_last & ~prev_q;
        end
    endgenerate

endmodule

// File: rtl/irq_req_capture.sv
// Request capture stage: latches synchronised request events as pending bits,
// clears them by indexed acknowledge and feeds the masked vector to the encoder.
module irq_req_capture
    import irq_pkg::*;
#(
    parameter int N           = N_IRQ,
    parameter int IDX_W       = IRQ_IDX_W,
    parameter int SYNC_STAGES = 2,
    parameter int LEVEL_MODE  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req_in,
    input  logic [N-1:0]     mask,
    input  logic             irq_en,
    input  logic             ack,
    input  logic [IDX_W-1:0] ack_idx,
    input  logic             ovf_clr,
    output logic [N-1:0]     d_out,
    output logic             enc_dis,
    output logic [N-1:0]     pending,
    output logic [N-1:0]     ovf,
    output logic [IDX_W:0]   pend_cnt,
    output logic             ack_err
);

    logic [N-1:0] evt;
    logic [N-1:0] clr_vec;
    logic [N-1:0] ovf_set;
    logic [N-1:0] pending_q, pending_d;
    logic [N-1:0] ovf_q, ovf_d;
    logic         ack_err_q, ack_err_d;

    irq_sync_edge #(
        .N           (N),
        .SYNC_STAGES (SYNC_STAGES),
        .LEVEL_MODE  (LEVEL_MODE)
    ) u_sync_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_in (req_in),
        .evt    (evt)
    );

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_bit
            assign clr_vec[gi] = ack && (ack_idx == IDX_W'(gi));
        end
    endgenerate

    // A new event beats a same-cycle acknowledge; that case is not an overflow.
    always_comb begin
        pending_d = evt | (pending_q & ~clr_vec);
        ovf_set   = (LEVEL_MODE != 0) ? '0 : (evt & pending_q & ~clr_vec);
        ovf_d     = ovf_set | (ovf_clr ? '0 : ovf_q);
        ack_err_d = ack & ~pending_q[ack_idx];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q <= '0;
            ovf_q     <= '0;
            ack_err_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            ack_err_q <= ack_err_d;
        end
    end

    assign pending  = pending_q;
    assign ovf      = ovf_q;
    assign ack_err  = ack_err_q;
    assign d_out    = pending_q & mask;
    assign enc_dis  = ~irq_en | ~(|d_out);
    assign pend_cnt = (IDX_W+1)'(irq_popcount(d_out));

endmodule

// File: tb/tb_irq_req_capture.sv
// Directed, table-driven check of irq_req_capture: each record is one clock
// cycle of inputs with the outputs expected just after that edge.
module tb_irq_req_capture;

    logic       clk;
    logic       rst_n;
    logic [7:0] req_in;
    logic [7:0] mask;
    logic       irq_en;
    logic       ack;
    logic [2:0] ack_idx;
    logic       ovf_clr;
    logic [7:0] d_out;
    logic       enc_dis;
    logic [7:0] pending;
    logic [7:0] ovf;
    logic [3:0] pend_cnt;
    logic       ack_err;

    int n_tests = 0;
    int n_fail  = 0;

    irq_req_capture dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_in   (req_in),
        .mask     (mask),
        .irq_en   (irq_en),
        .ack      (ack),
        .ack_idx  (ack_idx),
        .ovf_clr  (ovf_clr),
        .d_out    (d_out),
        .enc_dis  (enc_dis),
        .pending  (pending),
        .ovf      (ovf),
        .pend_cnt (pend_cnt),
        .ack_err  (ack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [7:0] req;
        logic [7:0] mask;
        logic       en;
        logic       ack;
        logic [2:0] idx;
        logic       oclr;
        logic [7:0] e_pend;
        logic [7:0] e_dout;
        logic       e_enc;
        logic [3:0] e_cnt;
        logic [7:0] e_ovf;
        logic       e_aerr;
    } vec_t;

    localparam int NV = 42;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic r, input logic [7:0] rq, input logic [7:0] m,
                                input logic en, input logic a, input logic [2:0] ix,
                                input logic oc, input logic [7:0] p, input logic [7:0] d,
                                input logic e, input logic [3:0] c, input logic [7:0] o,
                                input logic ae);
        vec_t v;
        v.rst_n = r;  v.req = rq;   v.mask = m;   v.en = en;
        v.ack = a;    v.idx = ix;   v.oclr = oc;
        v.e_pend = p; v.e_dout = d; v.e_enc = e;  v.e_cnt = c;
        v.e_ovf = o;  v.e_aerr = ae;
        return v;
    endfunction

    task automatic check8(input string tag, input int id, input logic [7:0] got,
                          input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL step%0d %s: got %02h, expected %02h", id, tag, got, exp);
        end
    endtask

    task automatic apply_vec(input int id, input vec_t v);
        rst_n   = v.rst_n;
        req_in  = v.req;
        mask    = v.mask;
        irq_en  = v.en;
        ack     = v.ack;
        ack_idx = v.idx;
        ovf_clr = v.oclr;
        @(posedge clk);
        #1;
        check8("pending",  id, pending,          v.e_pend);
        check8("d_out",    id, d_out,            v.e_dout);
        check8("enc_dis",  id, {7'd0, enc_dis},  {7'd0, v.e_enc});
        check8("pend_cnt", id, {4'd0, pend_cnt}, {4'd0, v.e_cnt});
        check8("ovf",      id, ovf,              v.e_ovf);
        check8("ack_err",  id, {7'd0, ack_err},  {7'd0, v.e_aerr});
        $display("[TB] step %0d req=%02h mask=%02h en=%0b ack=%0b/%0d oclr=%0b -> pend=%02h dout=%02h dis=%0b cnt=%0d ovf=%02h aerr=%0b",
                 id, v.req, v.mask, v.en, v.ack, v.idx, v.oclr,
                 pending, d_out, enc_dis, pend_cnt, ovf, ack_err);
    endtask

    initial begin
        rst_n = 1'b0; req_in = 8'h00; mask = 8'hFF; irq_en = 1'b1;
        ack = 1'b0; ack_idx = 3'd0; ovf_clr = 1'b0;

        //            rst req    mask   en ack idx oc  pend   dout   dis cnt ovf    aerr
        tbl[0]  = mk(0, 8'h00, 8'hFF, 1, 0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 0);
        tbl[1]  = mk(0, 8'h00, 8'hFF, 1, 0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 0);
        tbl[2]  = mk(1, 8'h00, 8'hFF, 1, 0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 0);
        tbl[3]  = mk(1, 8'h90, 8'hFF, 1, 0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 0);
        tbl[4]  = mk(1, 8'h90, 8'hFF, 1, 0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 0);
        tbl[5]  = mk(1, 8'h90, 8'hFF, 1, 0, 0, 0, 8'h90, 8'h90, 0, 2, 8'h00, 0);
        tbl[6]  = mk(1, 8'h90, 8'hFF, 1, 1, 7, 0, 8'h10, 8'h10, 0, 1, 8'h00, 0);
        tbl[7]  = mk(1, 8'h90, 8'hFF, 1, 1, 2, 0, 8'h10, 8'h10, 0, 1, 8'h00, 1);
        tbl[8]  = mk(1, 8'h90, 8'hFF, 1, 0, 0, 0, 8'h10, 8'h10, 0, 1, 8'h00, 0);
        tbl[9]  = mk(1, 8'h98, 8'hFF, 1, 0, 0, 0, 8'h10, 8'h10, 0, 1, 8'h00, 0);
        tbl[10] = mk(1, 8'h98, 8'hFF, 1, 0, 0, 0, 8'h10, 8'h10, 0, 1, 8'h00, 0);
        tbl[11] = mk(1, 8'h98, 8'hFF, 1, 0, 0, 0, 8'h18, 8'h18, 0, 2, 8'h00, 0);
        tbl[12] = mk(1, 8'h90, 8'hFF, 1, 0, 0, 0, 8'h18, 8'h18, 0, 2, 8'h00, 0);
        tbl[13] = mk(1, 8'h90, 8'hFF, 1, 0, 0, 0, 8'h18, 8'h18, 0, 2, 8'h00, 0);
        tbl[14] = mk(1, 8'h98, 8'hFF, 1, 0, 0, 0, 8'h18, 8'h18, 0, 2, 8'h00, 0);
        tbl[15] = mk(1, 8'h98, 8'hFF, 1, 0, 0, 0, 8'h18, 8'h18, 0, 2, 8'h00, 0);
        tbl[16] = mk(1, 8'h98, 8'hFF, 1, 0, 0, 0, 8'h18, 8'h18, 0, 2, 8'h08, 0);
        tbl[17] = mk(1, 8'h90, 8'hFF, 1, 0, 0, 1, 8'h18, 8'h18, 0, 2, 8'h00, 0);
        tbl[18] = mk(1, 8'h90, 8'hFF, 1, 0, 0, 0, 8'h18, 8'h18, 0, 2, 8'h00, 0);
        tbl[19] = mk(1, 8'h98, 8'hFF, 1, 0, 0, 0, 8'h18, 8'h18, 0, 2, 8'h00, 0);
        tbl[20] = mk(1, 8'h98, 8'hFF, 1, 0, 0, 0, 8'h18, 8'h18, 0, 2, 8'h00, 0);
        tbl[21] = mk(1, 8'h98, 8'hFF, 1, 1, 3, 0, 8'h18, 8'h18, 0, 2, 8'h00, 0);
        tbl[22] = mk(1, 8'h98, 8'hFF, 1, 1, 4, 0, 8'h08, 8'h08, 0, 1, 8'h00, 0);
        tbl[23] = mk(1, 8'h98, 8'hFF, 1, 1, 3, 0, 8'h00, 8'h00, 1, 0, 8'h00, 0);
        tbl[24] = mk(1, 8'h00, 8'hFF, 1, 0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 0);
        tbl[25] = mk(1, 8'h00, 8'hFF, 1, 0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 0);
        tbl[26] = mk(1, 8'h00, 8'hFF, 1, 0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 0);
        tbl[27] = mk(1, 8'hF0, 8'hFF, 1, 0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 0);
        tbl[28] = mk(1, 8'hF0, 8'hFF, 1, 0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 0);
        tbl[29] = mk(1, 8'hF0, 8'hFF, 1, 0, 0, 0, 8'hF0, 8'hF0, 0, 4, 8'h00, 0);
        tbl[30] = mk(1, 8'hF0, 8'h0F, 1, 0, 0, 0, 8'hF0, 8'h00, 1, 0, 8'h00, 0);
        tbl[31] = mk(1, 8'hF0, 8'hFF, 1, 0, 0, 0, 8'hF0, 8'hF0, 0, 4, 8'h00, 0);
        tbl[32] = mk(1, 8'hF0, 8'hFF, 0, 0, 0, 0, 8'hF0, 8'hF0, 1, 4, 8'h00, 0);
        tbl[33] = mk(1, 8'hFF, 8'hFF, 1, 0, 0, 0, 8'hF0, 8'hF0, 0, 4, 8'h00, 0);
        tbl[34] = mk(1, 8'hFF, 8'hFF, 1, 0, 0, 0, 8'hF0, 8'hF0, 0, 4, 8'h00, 0);
        tbl[35] = mk(1, 8'hFF, 8'hFF, 1, 0, 0, 0, 8'hFF, 8'hFF, 0, 8, 8'h00, 0);
        tbl[36] = mk(0, 8'h01, 8'hFF, 1, 0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 0);
        tbl[37] = mk(1, 8'h01, 8'hFF, 1, 0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 0);
        tbl[38] = mk(1, 8'h01, 8'hFF, 1, 0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 0);
        tbl[39] = mk(1, 8'h01, 8'hFF, 1, 0, 0, 0, 8'h01, 8'h01, 0, 1, 8'h00, 0);
        tbl[40] = mk(1, 8'h01, 8'hFF, 1, 0, 0, 0, 8'h01, 8'h01, 0, 1, 8'h00, 0);
        tbl[41] = mk(1, 8'h01, 8'hFF, 1, 0, 0, 0, 8'h01, 8'h01, 0, 1, 8'h00, 0);

        for (int i = 0; i < NV; i++) begin
            apply_vec(i, tbl[i]);
        end

        // Re-trigger bit 0 while it is still pending and clear overflow in
        // the same cycle: the new overflow must survive the clear.
        apply_vec(100, mk(1, 8'h00, 8'hFF, 1, 0, 0, 0, 8'h01, 8'h01, 0, 1, 8'h00, 0));
        apply_vec(101, mk(1, 8'h00, 8'hFF, 1, 0, 0, 0, 8'h01, 8'h01, 0, 1, 8'h00, 0));
        apply_vec(102, mk(1, 8'h00, 8'hFF, 1, 0, 0, 0, 8'h01, 8'h01, 0, 1, 8'h00, 0));
        apply_vec(103, mk(1, 8'h01, 8'hFF, 1, 0, 0, 0, 8'h01, 8'h01, 0, 1, 8'h00, 0));
        apply_vec(104, mk(1, 8'h01, 8'hFF, 1, 0, 0, 0, 8'h01, 8'h01, 0, 1, 8'h00, 0));
        apply_vec(105, mk(1, 8'h01, 8'hFF, 1, 0, 0, 1, 8'h01, 8'h01, 0, 1, 8'h01, 0));
        apply_vec(106, mk(1, 8'h01, 8'hFF, 1, 0, 0, 1, 8'h01, 8'h01, 0, 1, 8'h00, 0));

        // Acknowledge bit 0, then acknowledge it again once it is clear.
        apply_vec(107, mk(1, 8'h01, 8'hFF, 1, 1, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 0));
        apply_vec(108, mk(1, 8'h01, 8'hFF, 1, 1, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 1));
        apply_vec(109, mk(1, 8'h01, 8'hFF, 1, 0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
